uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: BAUD_DIV, 32-bit, default 868; clock cycles per bit (100 MHz / 115200 baud).
REQ-002 clk  input  1  system clock, 100 MHz; all logic on posedge clk.
REQ-003 resetn  input  1  reset; asynchronous, active-low.
REQ-004 rx  input  1  asynchronous serial line; idles high.
REQ-005 data  output  8  received byte; stable while dvalid is high.
REQ-006 dvalid  output  1  received byte available; held high until consumed.
REQ-007 ready  input  1  consumer accepts data in any cycle where dvalid and ready are both high.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit was sampled low.
REQ-009 overrun  output  1  one-cycle pulse: a new byte was lost because the holding register was full.

Function
REQ-010 The block SHALL pass rx through a two-flop synchronizer; both flops reset to 1. rx_s is the synchronizer output.
REQ-011 The block SHALL keep a registered copy rx_d of rx_s and detect a start edge as rx_d==1 and rx_s==0.
REQ-012 The FSM SHALL have four states: IDLE, START, DATA and STOP. It resets to IDLE.
REQ-013 IDLE: on a start edge, the FSM SHALL go to START and clear the divider (div_count) to 0. A line held low SHALL NOT retrigger.
REQ-014 The 32-bit div_count SHALL increment each cycle outside IDLE. It SHALL clear on the state's terminal count and on every state change.
REQ-015 START: at div_count == BAUD_DIV/2 - 1 (integer division), the FSM SHALL sample rx_s. If the sample is 0, go to DATA. If it is 1 (glitch), go to IDLE with no output.
REQ-016 DATA: at each div_count == BAUD_DIV-1, the block SHALL shift rx_s into bit 7 of an 8-bit shift register (right shift, LSB first) and increment a 4-bit bit counter. After the 8th sample it goes to STOP.
REQ-017 STOP, at div_count == BAUD_DIV-1, stop bit sampled 1: the block SHALL load the shift register into data and set dvalid. The FSM goes to IDLE.
REQ-018 STOP, at div_count == BAUD_DIV-1, stop bit sampled 0: the block SHALL pulse frame_err for one cycle, leave data and dvalid unchanged, and go to IDLE.
REQ-019 Latency: dvalid SHALL rise one clock after the stop-bit sample cycle.
REQ-020 dvalid SHALL clear in the cycle after a cycle where dvalid and ready are both high.
REQ-021 Load while dvalid=1 and ready=0: the block SHALL keep the old data, drop the new byte and pulse overrun for one cycle.
REQ-022 Load in the same cycle as a consume (dvalid=1, ready=1): the new byte SHALL load, dvalid SHALL stay 1 and there SHALL be no overrun.
REQ-023 ready SHALL have no effect while dvalid=0.
REQ-024 A start edge during START, DATA or STOP SHALL be ignored. A new frame is only recognised from IDLE.
REQ-025 BAUD_DIV < 4 is unsupported. The block SHALL flag it with an elaboration-time assertion.

Reset
REQ-026 Reset SHALL set: data=0x00, dvalid=0, frame_err=0, overrun=0, FSM=IDLE, div_count=0, bit counter=0, shift register=0x00, synchronizer flops and rx_d=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output. After release, the block SHALL wait for a fresh start edge.

Structure
REQ-028 Package uart_pkg SHALL hold the RX state enum, the START (1'b0) and STOP (1'b1) bit constants, and the default BAUD_DIV of 868.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, reset value 1). Everything else stays in uart_rx.

Verification
REQ-030 Loopback from the team's UART transmitter, byte 0xA5, ready=1: dvalid pulses once with data=0xA5, about 9.5 x 868 cycles after the start edge; frame_err=0, overrun=0.
REQ-031 rx low for 200 cycles, then high: dvalid, frame_err and overrun stay 0; FSM returns to IDLE; a following byte 0x3C is received correctly.
REQ-032 Frame 0x5A with stop bit driven 0: exactly one frame_err pulse, dvalid stays 0. Line then held low for 20 bit times: no further pulses.
REQ-033 Bytes 0x11 then 0x22 with ready=0: data=0x11, dvalid=1, and one overrun pulse at the second stop sample. Then ready=1 for one cycle: dvalid clears.
REQ-034 Reset pulsed during bit 4 of byte 0xFF: outputs return to reset values. After release, byte 0x81 is received correctly.
REQ-035 Back-to-back 0x00 and 0xFF frames, with ready asserted exactly in the load cycle of the second byte: both bytes are delivered and there is no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, line-level
// bit constants and the default divider for 115200 baud at 100 MHz.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int BAUD_DIV_DEFAULT = 868;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset high
// so an idle serial line never looks like a start bit coming out of reset.
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry holding register.
// Handshake: a byte is transferred in every cycle where dvalid and ready are both high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       dvalid,
  output logic       frame_err,
  output logic       overrun,
  output logic [1:0] fsm_state
);

  localparam logic [31:0] HALF_CNT = 32'(BAUD_DIV / 2 - 1);
  localparam logic [31:0] FULL_CNT = 32'(BAUD_DIV - 1);

  generate
    if (BAUD_DIV < 4) begin : g_bad_baud_div
      $error("uart_rx: BAUD_DIV must be at least 4");
    end
  endgenerate

  rx_state_t   state;
  logic        rx_s;
  logic        rx_d;
  logic [31:0] div_count;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        start_edge;

  sync_2ff u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rx),
    .q      (rx_s)
  );

  // Falling edge only; a line held low produces a single edge.
  assign start_edge = rx_d & ~rx_s;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rx_d      <= 1'b1;
      div_count <= 32'd0;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      dvalid    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_d      <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (dvalid && ready) begin
        dvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          div_count <= 32'd0;
          bit_cnt   <= 4'd0;
          if (start_edge) begin
            state <= START;
          end
        end

        START: begin
          if (div_count == HALF_CNT) begin
            div_count <= 32'd0;
            state     <= (rx_s == START_BIT) ? DATA : IDLE;
          end else begin
            div_count <= div_count + 32'd1;
          end
        end

        DATA: begin
          if (div_count == FULL_CNT) begin
            div_count <= 32'd0;
            shift     <= {rx_s, shift[7:1]};
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            div_count <= div_count + 32'd1;
          end
        end

        STOP: begin
          if (div_count == FULL_CNT) begin
            div_count <= 32'd0;
            state     <= IDLE;
            if (rx_s == STOP_BIT) begin
              // A consume in this same cycle frees the register for the new byte.
              if (dvalid && !ready) begin
                overrun <= 1'b1;
              end else begin
                data   <= shift;
                dvalid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            div_count <= div_count + 32'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written
// sequences for glitch, break, overrun, mid-frame reset and back-to-back cases.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int B        = 16;
  localparam int HALF     = B / 2 - 1;
  // Start drive edge to load edge: two sync flops, edge register, half bit, nine bits.
  localparam int LOAD_LAT = 4 + HALF + 9 * B;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       dvalid;
  logic       frame_err;
  logic       overrun;
  logic [1:0] fsm_state;

  uart_rx #(.BAUD_DIV(B)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .ready     (ready),
    .data      (data),
    .dvalid    (dvalid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int dv_rises = 0;
  int dv_rise_cyc = -1;
  int start_cyc = 0;
  logic dv_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  typedef struct {
    logic [7:0] value;
    logic       stop;
    int         exp_fe;
    logic       exp_dv;
  } vec_t;

  vec_t vecs[7];

  always @(posedge clk) cyc++;

  // Scoreboard: every consumed byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (dvalid && !dv_prev) begin
      dv_rises++;
      dv_rise_cyc = cyc;
    end
    dv_prev = dvalid;
    if (dvalid && ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL consume: got=%02h want=no byte", data);
      end else begin
        exp_b = exp_q.pop_front();
        if (data !== exp_b) begin
          bad++;
          $display("FAIL consume: got=%02h want=%02h", data, exp_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    fe_cnt = 0;
    ov_cnt = 0;
    dv_rises = 0;
    dv_rise_cyc = -1;
  endtask

  // Drives one frame LSB first; leaves rx at the stop-bit level on return.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 rx = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (B) @(posedge clk);
    #1 rx = stop;
    repeat (B) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int delta;

    vecs[0] = '{8'hA5, 1'b1, 0, 1'b1};
    vecs[1] = '{8'h3C, 1'b1, 0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 0, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 0, 1'b1};
    vecs[4] = '{8'h55, 1'b1, 0, 1'b1};
    vecs[5] = '{8'h5A, 1'b0, 1, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 0, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 32'h00);
    check("rst_dvalid", 32'(dvalid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    resetn = 1'b1;
    ready = 1'b1;
    repeat (4) @(posedge clk);

    // Table of single frames with ready held high
    for (int v = 0; v < 7; v++) begin
      clear_counts();
      if (vecs[v].exp_dv) exp_q.push_back(vecs[v].value);
      send_byte(vecs[v].value, vecs[v].stop);
      #1 rx = 1'b1;
      repeat (B) @(posedge clk);
      #1;
      check("vec_frame_err", 32'(fe_cnt), 32'(vecs[v].exp_fe));
      check("vec_overrun", 32'(ov_cnt), 0);
      check("vec_dv_rises", 32'(dv_rises), 32'(vecs[v].exp_dv));
      check("vec_pending", 32'(exp_q.size()), 0);
      check("vec_state", 32'(fsm_state), 32'(IDLE));
      if (v == 0) begin
        delta = dv_rise_cyc - start_cyc;
        check("latency_window", 32'(delta >= 9 * B && delta <= 10 * B), 1);
      end
    end

    // Short low glitch: rejected at the mid-start sample
    clear_counts();
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * B) @(posedge clk);
    #1;
    check("glitch_frame_err", 32'(fe_cnt), 0);
    check("glitch_overrun", 32'(ov_cnt), 0);
    check("glitch_dv_rises", 32'(dv_rises), 0);
    check("glitch_state", 32'(fsm_state), 32'(IDLE));
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    repeat (B) @(posedge clk);
    #1 check("glitch_next_pending", 32'(exp_q.size()), 0);

    // Bad stop bit, then the line held low for 20 bit times
    clear_counts();
    send_byte(8'h5A, 1'b0);
    repeat (20 * B) @(posedge clk);
    #1;
    check("break_frame_err", 32'(fe_cnt), 1);
    check("break_dvalid", 32'(dvalid), 0);
    check("break_overrun", 32'(ov_cnt), 0);
    rx = 1'b1;
    repeat (B) @(posedge clk);

    // Two bytes with ready low: second is dropped with an overrun pulse
    #1 ready = 1'b0;
    clear_counts();
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (B) @(posedge clk);
    #1;
    check("ovr_data", 32'(data), 32'h11);
    check("ovr_dvalid", 32'(dvalid), 1);
    check("ovr_pulses", 32'(ov_cnt), 1);
    check("ovr_frame_err", 32'(fe_cnt), 0);
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    check("ovr_consume_clear", 32'(dvalid), 0);
    check("ovr_pending", 32'(exp_q.size()), 0);

    // Reset in the middle of bit 4 of 0xFF
    @(posedge clk);
    #1 ready = 1'b1;
    clear_counts();
    fork
      send_byte(8'hFF, 1'b1);
      begin
        @(posedge clk);
        repeat (5 * B + B / 2) @(posedge clk);
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_dvalid", 32'(dvalid), 0);
        check("midrst_state", 32'(fsm_state), 32'(IDLE));
        resetn = 1'b1;
      end
    join
    repeat (B) @(posedge clk);
    #1;
    check("midrst_dv_rises", 32'(dv_rises), 0);
    check("midrst_frame_err", 32'(fe_cnt), 0);
    check("midrst_state_after", 32'(fsm_state), 32'(IDLE));
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    repeat (B) @(posedge clk);
    #1 check("midrst_next_pending", 32'(exp_q.size()), 0);

    // Back-to-back 0x00, 0xFF; ready only in the load cycle of the second byte
    ready = 1'b0;
    clear_counts();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    fork
      begin
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
      end
      begin
        @(posedge clk);
        repeat (10 * B + 1 + LOAD_LAT - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    #1;
    check("b2b_data", 32'(data), 32'hFF);
    check("b2b_dvalid", 32'(dvalid), 1);
    check("b2b_dv_rises", 32'(dv_rises), 1);
    check("b2b_overrun", 32'(ov_cnt), 0);
    check("b2b_pending_one", 32'(exp_q.size()), 1);
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    check("b2b_pending", 32'(exp_q.size()), 0);
    check("b2b_dvalid_clear", 32'(dvalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
